// File: rtl/muldiv_pkg.sv
// muldiv_pkg: shared definitions for the muldiv32 multiply/divide unit.
//   - op encodings (mult, multu, div, divu)
//   - controller state enum (IDLE / CALC / FIX)
//   - quotient value returned on a divide by zero (all-ones, truncated to WIDTH)
package muldiv_pkg;

    localparam logic [1:0] OP_MULT  = 2'b00;
    localparam logic [1:0] OP_MULTU = 2'b01;
    localparam logic [1:0] OP_DIV   = 2'b10;
    localparam logic [1:0] OP_DIVU  = 2'b11;

    // Wide enough for any supported WIDTH; users slice the low WIDTH bits.
    localparam logic [127:0] DIV0_QUOTIENT = {128{1'b1}};

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        CALC = 2'b01,
        FIX  = 2'b10
    } state_t;

endpackage

// File: rtl/muldiv32_if.sv
// muldiv32_if: request/response bundle between the decode stage and muldiv32.
//   start/op/operand_a/operand_b : operation request (master -> slave)
//   hi_we/lo_we/wdata            : mthi/mtlo writes   (master -> slave)
//   busy/done/hi/lo              : status and HI/LO   (slave -> master)
interface muldiv32_if #(
    parameter int WIDTH = 32
);
    import muldiv_pkg::*;

    logic             start;
    logic [1:0]       op;
    logic [WIDTH-1:0] operand_a;
    logic [WIDTH-1:0] operand_b;
    logic             hi_we;
    logic             lo_we;
    logic [WIDTH-1:0] wdata;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output start, op, operand_a, operand_b, hi_we, lo_we, wdata,
        input  busy, done, hi, lo
    );

    modport slave (
        input  start, op, operand_a, operand_b, hi_we, lo_we, wdata,
        output busy, done, hi, lo
    );

endinterface

// File: rtl/muldiv_div_step.sv
// muldiv_div_step: one combinational restoring-division iteration.
//   i_rem     : partial remainder (always < divisor, except for a zero divisor)
//   i_bit     : next dividend bit shifted in at the bottom
//   i_divisor : divisor magnitude
//   o_rem     : next partial remainder
//   o_qbit    : quotient bit produced by this iteration
module muldiv_div_step
    import muldiv_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] i_rem,
    input  logic             i_bit,
    input  logic [WIDTH-1:0] i_divisor,
    output logic [WIDTH-1:0] o_rem,
    output logic             o_qbit
);

    logic [WIDTH:0]   w_shifted;
    logic [WIDTH-1:0] w_diff;
    logic             w_ge;

    // Trial subtraction; the difference always fits WIDTH bits when it is kept.
    always_comb begin
        w_shifted = {i_rem, i_bit};
        w_ge      = (w_shifted >= {1'b0, i_divisor});
        w_diff    = w_shifted[WIDTH-1:0] - i_divisor;
        if (w_ge) begin
            o_rem  = w_diff;
            o_qbit = 1'b1;
        end else begin
            o_rem  = w_shifted[WIDTH-1:0];
            o_qbit = 1'b0;
        end
    end

endmodule

// File: rtl/muldiv32.sv
// muldiv32: iterative multiply/divide unit with architectural HI/LO.
//   clock : rising-edge clock
//   reset : asynchronous active-low reset
//   bus   : muldiv32_if.slave (start/op/operands, mthi/mtlo writes, busy/done/hi/lo)
// An accepted operation iterates WIDTH times in CALC, then FIX applies the sign
// correction and writes HI/LO. mult/div take magnitudes; sign is restored in FIX.
// Build option MULDIV32_DIV0_FAST_EN: a divide by zero skips CALC and goes
// straight to FIX (result is identical, only the latency changes).
module muldiv32
    import muldiv_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic       clock,
    input  logic       reset,
    muldiv32_if.slave  bus
);

    localparam int            CW       = $clog2(WIDTH);
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    state_t             r_state;
    state_t             w_next_state;
    logic [CW-1:0]      r_cnt;
    logic [2*WIDTH-1:0] r_acc;      // mult: {partial product, multiplier}; div: {remainder, dividend/quotient}
    logic [WIDTH-1:0]   r_b;        // multiplicand / divisor magnitude
    logic [WIDTH-1:0]   r_a_raw;    // untouched operand_a for the divide-by-zero HI value
    logic [1:0]         r_op;
    logic               r_sign_a;
    logic               r_sign_b;
    logic               r_div0;
    logic               r_busy;
    logic               r_done;
    logic [WIDTH-1:0]   r_hi;
    logic [WIDTH-1:0]   r_lo;

    logic               w_accept;
    logic               w_iter;
    logic               w_fix;
    logic               w_wr_hi;
    logic               w_wr_lo;
    logic               w_signed_in;
    logic               w_b_zero;
    logic [WIDTH:0]     w_mul_sum;
    logic [WIDTH-1:0]   w_rem_next;
    logic               w_qbit;
    logic [2*WIDTH-1:0] w_prod;
    logic [WIDTH-1:0]   w_quo_fix;
    logic [WIDTH-1:0]   w_rem_fix;
    logic [WIDTH-1:0]   w_fix_hi;
    logic [WIDTH-1:0]   w_fix_lo;

    function automatic logic [WIDTH-1:0] f_mag(input logic [WIDTH-1:0] v, input logic neg);
        f_mag = neg ? (~v + {{(WIDTH-1){1'b0}}, 1'b1}) : v;
    endfunction

    assign w_signed_in = ~bus.op[0];
    assign w_b_zero    = (bus.operand_b == {WIDTH{1'b0}});

    muldiv_div_step #(.WIDTH(WIDTH)) u_div_step (
        .i_rem     (r_acc[2*WIDTH-1:WIDTH]),
        .i_bit     (r_acc[WIDTH-1]),
        .i_divisor (r_b),
        .o_rem     (w_rem_next),
        .o_qbit    (w_qbit)
    );

    // State register.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state and per-cycle control; start has priority over mthi/mtlo in IDLE.
    always_comb begin
        w_next_state = r_state;
        w_accept     = 1'b0;
        w_iter       = 1'b0;
        w_fix        = 1'b0;
        w_wr_hi      = 1'b0;
        w_wr_lo      = 1'b0;
        case (r_state)
            IDLE: begin
                if (bus.start) begin
                    w_accept = 1'b1;
`ifdef MULDIV32_DIV0_FAST_EN
                    if (bus.op[1] && w_b_zero) begin
                        w_next_state = FIX;
                    end else begin
                        w_next_state = CALC;
                    end
`else
                    w_next_state = CALC;
`endif
                end else begin
                    w_wr_hi = bus.hi_we;
                    w_wr_lo = bus.lo_we;
                end
            end
            CALC: begin
                w_iter = 1'b1;
                if (r_cnt == CNT_LAST) begin
                    w_next_state = FIX;
                end else begin
                    w_next_state = CALC;
                end
            end
            FIX: begin
                w_fix        = 1'b1;
                w_next_state = IDLE;
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase
    end

    // Iteration arithmetic and sign correction of the final result.
    always_comb begin
        // Shift-add: add multiplicand to the upper half when the multiplier LSB is set.
        w_mul_sum = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + ({1'b0, r_b} & {(WIDTH+1){r_acc[0]}});
        if (~r_op[0] && (r_sign_a ^ r_sign_b)) begin
            w_prod    = ~r_acc + {{(2*WIDTH-1){1'b0}}, 1'b1};
            w_quo_fix = f_mag(r_acc[WIDTH-1:0], 1'b1);
        end else begin
            w_prod    = r_acc;
            w_quo_fix = r_acc[WIDTH-1:0];
        end
        // Remainder follows the dividend's sign.
        w_rem_fix = f_mag(r_acc[2*WIDTH-1:WIDTH], ~r_op[0] & r_sign_a);
        if (r_op[1]) begin
            if (r_div0) begin
                w_fix_hi = r_a_raw;
                w_fix_lo = DIV0_QUOTIENT[WIDTH-1:0];
            end else begin
                w_fix_hi = w_rem_fix;
                w_fix_lo = w_quo_fix;
            end
        end else begin
            w_fix_hi = w_prod[2*WIDTH-1:WIDTH];
            w_fix_lo = w_prod[WIDTH-1:0];
        end
    end

    // Datapath, counter, HI/LO and status registers.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_cnt    <= {CW{1'b0}};
            r_acc    <= {(2*WIDTH){1'b0}};
            r_b      <= {WIDTH{1'b0}};
            r_a_raw  <= {WIDTH{1'b0}};
            r_op     <= 2'b00;
            r_sign_a <= 1'b0;
            r_sign_b <= 1'b0;
            r_div0   <= 1'b0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_hi     <= {WIDTH{1'b0}};
            r_lo     <= {WIDTH{1'b0}};
        end else if (w_accept) begin
            // Both algorithms start from {0, |a|} with |b| as the second operand.
            r_cnt    <= {CW{1'b0}};
            r_acc    <= {{WIDTH{1'b0}}, f_mag(bus.operand_a, w_signed_in & bus.operand_a[WIDTH-1])};
            r_b      <= f_mag(bus.operand_b, w_signed_in & bus.operand_b[WIDTH-1]);
            r_a_raw  <= bus.operand_a;
            r_op     <= bus.op;
            r_sign_a <= w_signed_in & bus.operand_a[WIDTH-1];
            r_sign_b <= w_signed_in & bus.operand_b[WIDTH-1];
            r_div0   <= bus.op[1] & w_b_zero;
            r_busy   <= 1'b1;
            r_done   <= 1'b0;
        end else if (w_iter) begin
            if (r_op[1]) begin
                r_acc <= {w_rem_next, r_acc[WIDTH-2:0], w_qbit};
            end else begin
                r_acc <= {w_mul_sum, r_acc[WIDTH-1:1]};
            end
            if (r_cnt == CNT_LAST) begin
                r_cnt <= {CW{1'b0}};
            end else begin
                r_cnt <= r_cnt + CW'(1);
            end
            r_done <= 1'b0;
        end else if (w_fix) begin
            r_hi   <= w_fix_hi;
            r_lo   <= w_fix_lo;
            r_busy <= 1'b0;
            r_done <= 1'b1;
        end else begin
            r_done <= 1'b0;
            if (w_wr_hi) begin
                r_hi <= bus.wdata;
            end else begin
                r_hi <= r_hi;
            end
            if (w_wr_lo) begin
                r_lo <= bus.wdata;
            end else begin
                r_lo <= r_lo;
            end
        end
    end

    assign bus.busy = r_busy;
    assign bus.done = r_done;
    assign bus.hi   = r_hi;
    assign bus.lo   = r_lo;

endmodule

// File: tb/tb_muldiv32.sv
module tb_muldiv32;

    logic clk;
    logic rst_n;
    int   n_vec;
    int   n_err;

    muldiv32_if #(.WIDTH(32)) bus ();

    muldiv32 #(.WIDTH(32)) dut (
        .clock (clk),
        .reset (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

`ifdef MULDIV32_DIV0_FAST_EN
    localparam int DIV0_LAT = 1;
`else
    localparam int DIV0_LAT = 33;
`endif

    // Issue one operation at a negedge; lat = edges from the accept edge to done.
    // Operands are scrambled right after the accept edge.
    task automatic do_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic with_lo_we, output int lat, output logic busy_after);
        @(negedge clk);
        bus.start = 1'b1; bus.op = op; bus.operand_a = a; bus.operand_b = b;
        bus.lo_we = with_lo_we; bus.wdata = 32'hDEAD_BEEF;
        @(posedge clk);
        #1;
        busy_after = bus.busy;
        bus.start = 1'b0; bus.lo_we = 1'b0;
        bus.operand_a = 32'hFFFF_FFFF; bus.operand_b = 32'h0000_0001;
        lat = 0;
        while (lat < 100) begin
            @(posedge clk);
            lat++;
            #1;
            if (bus.done) break;
        end
    endtask

    task automatic test_reset();
        #12;
        n_vec++; if (bus.busy !== 1'b0) begin n_err++; $display("FAIL reset_busy got=%b exp=0", bus.busy); end
        n_vec++; if (bus.done !== 1'b0) begin n_err++; $display("FAIL reset_done got=%b exp=0", bus.done); end
        n_vec++; if (bus.hi !== 32'h0) begin n_err++; $display("FAIL reset_hi got=%h exp=0", bus.hi); end
        n_vec++; if (bus.lo !== 32'h0) begin n_err++; $display("FAIL reset_lo got=%h exp=0", bus.lo); end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_mult();
        int lat; logic ba;
        do_op(2'b00, 32'hFFFF_FFFF, 32'h0000_0002, 1'b0, lat, ba);
        n_vec++; if (ba !== 1'b1) begin n_err++; $display("FAIL mult_busy got=%b exp=1", ba); end
        n_vec++; if (lat !== 33) begin n_err++; $display("FAIL mult_latency got=%0d exp=33", lat); end
        n_vec++; if (bus.busy !== 1'b0) begin n_err++; $display("FAIL mult_busy_end got=%b exp=0", bus.busy); end
        n_vec++; if (bus.hi !== 32'hFFFF_FFFF) begin n_err++; $display("FAIL mult_hi got=%h exp=ffffffff", bus.hi); end
        n_vec++; if (bus.lo !== 32'hFFFF_FFFE) begin n_err++; $display("FAIL mult_lo got=%h exp=fffffffe", bus.lo); end
        @(posedge clk); #1;
        n_vec++; if (bus.done !== 1'b0) begin n_err++; $display("FAIL mult_done_pulse got=%b exp=0", bus.done); end
        do_op(2'b01, 32'hFFFF_FFFF, 32'h0000_0002, 1'b0, lat, ba);
        n_vec++; if (bus.hi !== 32'h0000_0001) begin n_err++; $display("FAIL multu_hi got=%h exp=00000001", bus.hi); end
        n_vec++; if (bus.lo !== 32'hFFFF_FFFE) begin n_err++; $display("FAIL multu_lo got=%h exp=fffffffe", bus.lo); end
    endtask

    task automatic test_div();
        int lat; logic ba;
        do_op(2'b10, 32'hFFFF_FFF9, 32'h0000_0002, 1'b0, lat, ba);
        n_vec++; if (bus.lo !== 32'hFFFF_FFFD) begin n_err++; $display("FAIL div_neg_lo got=%h exp=fffffffd", bus.lo); end
        n_vec++; if (bus.hi !== 32'hFFFF_FFFF) begin n_err++; $display("FAIL div_neg_hi got=%h exp=ffffffff", bus.hi); end
        do_op(2'b11, 32'h0000_0007, 32'h0000_0002, 1'b0, lat, ba);
        n_vec++; if (lat !== 33) begin n_err++; $display("FAIL divu_latency got=%0d exp=33", lat); end
        n_vec++; if (bus.lo !== 32'h0000_0003) begin n_err++; $display("FAIL divu_lo got=%h exp=00000003", bus.lo); end
        n_vec++; if (bus.hi !== 32'h0000_0001) begin n_err++; $display("FAIL divu_hi got=%h exp=00000001", bus.hi); end
        do_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, lat, ba);
        n_vec++; if (bus.lo !== 32'h8000_0000) begin n_err++; $display("FAIL div_ovf_lo got=%h exp=80000000", bus.lo); end
        n_vec++; if (bus.hi !== 32'h0000_0000) begin n_err++; $display("FAIL div_ovf_hi got=%h exp=00000000", bus.hi); end
    endtask

    task automatic test_div0();
        int lat; logic ba;
        do_op(2'b11, 32'h1234_5678, 32'h0000_0000, 1'b0, lat, ba);
        n_vec++; if (lat !== DIV0_LAT) begin n_err++; $display("FAIL div0_latency got=%0d exp=%0d", lat, DIV0_LAT); end
        n_vec++; if (bus.hi !== 32'h1234_5678) begin n_err++; $display("FAIL div0_hi got=%h exp=12345678", bus.hi); end
        n_vec++; if (bus.lo !== 32'hFFFF_FFFF) begin n_err++; $display("FAIL div0_lo got=%h exp=ffffffff", bus.lo); end
    endtask

    task automatic test_mthi_mtlo();
        @(negedge clk);
        bus.hi_we = 1'b1; bus.wdata = 32'hA5A5_A5A5;
        @(posedge clk); #1;
        bus.hi_we = 1'b0;
        n_vec++; if (bus.hi !== 32'hA5A5_A5A5) begin n_err++; $display("FAIL mthi got=%h exp=a5a5a5a5", bus.hi); end
        @(negedge clk);
        bus.lo_we = 1'b1; bus.wdata = 32'h5A5A_5A5A;
        @(posedge clk); #1;
        bus.lo_we = 1'b0;
        n_vec++; if (bus.lo !== 32'h5A5A_5A5A) begin n_err++; $display("FAIL mtlo got=%h exp=5a5a5a5a", bus.lo); end
        n_vec++; if (bus.hi !== 32'hA5A5_A5A5) begin n_err++; $display("FAIL mtlo_hi_kept got=%h exp=a5a5a5a5", bus.hi); end
    endtask

    task automatic test_busy_ignore();
        int lat;
        @(negedge clk);
        bus.start = 1'b1; bus.op = 2'b01; bus.operand_a = 32'h10; bus.operand_b = 32'h10;
        @(posedge clk); #1;
        bus.start = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        bus.start = 1'b1; bus.op = 2'b11; bus.operand_a = 32'h7; bus.operand_b = 32'h2;
        bus.lo_we = 1'b1; bus.wdata = 32'h5A5A_5A5A;
        @(posedge clk); #1;
        bus.start = 1'b0; bus.lo_we = 1'b0;
        lat = 6;
        while (lat < 100) begin
            @(posedge clk);
            lat++;
            #1;
            if (bus.done) break;
        end
        n_vec++; if (lat !== 33) begin n_err++; $display("FAIL busy_ign_latency got=%0d exp=33", lat); end
        n_vec++; if (bus.lo !== 32'h0000_0100) begin n_err++; $display("FAIL busy_ign_lo got=%h exp=00000100", bus.lo); end
        n_vec++; if (bus.hi !== 32'h0000_0000) begin n_err++; $display("FAIL busy_ign_hi got=%h exp=00000000", bus.hi); end
        @(posedge clk); #1;
        n_vec++; if (bus.busy !== 1'b0) begin n_err++; $display("FAIL busy_ign_no_second got=%b exp=0", bus.busy); end
    endtask

    task automatic test_start_wins();
        int lat; logic ba;
        do_op(2'b01, 32'h0001_0001, 32'h0003_0000, 1'b1, lat, ba);
        n_vec++; if (bus.hi !== 32'h0000_0003) begin n_err++; $display("FAIL start_wins_hi got=%h exp=00000003", bus.hi); end
        n_vec++; if (bus.lo !== 32'h0003_0000) begin n_err++; $display("FAIL start_wins_lo got=%h exp=00030000", bus.lo); end
    endtask

    task automatic test_reset_mid();
        int lat; logic ba; logic saw_done;
        @(negedge clk);
        bus.start = 1'b1; bus.op = 2'b11; bus.operand_a = 32'h0000_0064; bus.operand_b = 32'h0000_0007;
        @(posedge clk); #1;
        bus.start = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        n_vec++; if (bus.busy !== 1'b0) begin n_err++; $display("FAIL rst_mid_busy got=%b exp=0", bus.busy); end
        n_vec++; if (bus.hi !== 32'h0) begin n_err++; $display("FAIL rst_mid_hi got=%h exp=0", bus.hi); end
        n_vec++; if (bus.lo !== 32'h0) begin n_err++; $display("FAIL rst_mid_lo got=%h exp=0", bus.lo); end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        saw_done = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (bus.done) saw_done = 1'b1;
        end
        n_vec++; if (saw_done !== 1'b0) begin n_err++; $display("FAIL rst_mid_no_done got=%b exp=0", saw_done); end
        do_op(2'b00, 32'h0000_0003, 32'h0000_0005, 1'b0, lat, ba);
        n_vec++; if (lat !== 33) begin n_err++; $display("FAIL post_rst_latency got=%0d exp=33", lat); end
        n_vec++; if (bus.lo !== 32'h0000_000F) begin n_err++; $display("FAIL post_rst_lo got=%h exp=0000000f", bus.lo); end
        n_vec++; if (bus.hi !== 32'h0000_0000) begin n_err++; $display("FAIL post_rst_hi got=%h exp=00000000", bus.hi); end
    endtask

    initial begin
        n_vec = 0; n_err = 0;
        rst_n = 1'b0;
        bus.start = 1'b0; bus.op = 2'b00; bus.operand_a = 32'h0; bus.operand_b = 32'h0;
        bus.hi_we = 1'b0; bus.lo_we = 1'b0; bus.wdata = 32'h0;
        test_reset();
        test_mult();
        test_div();
        test_div0();
        test_mthi_mtlo();
        test_busy_ignore();
        test_start_wins();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/muldiv32.md
Name: muldiv32

Overview:
- Iterative multiply/divide unit with architectural HI/LO registers.
- Sits downstream of the register-file decode stage, beside the ALU. Consumes rs/rt read data and executes mult, multu, div and divu.
- Also services mthi/mtlo writes and drives HI/LO back toward writeback for mfhi/mflo.
- Asserts busy so the fetch/control logic can stall the pipeline while an operation is in flight.

Parameters:
- WIDTH, 32, operand width. Must be even and at least 4. Iteration count equals WIDTH.

Ports:
- clock  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset
- start  in  1  request to begin an operation; sampled only in IDLE
- op  in  2  operation select: 00 mult, 01 multu, 10 div, 11 divu
- operand_a  in  WIDTH  rs value (multiplicand / dividend)
- operand_b  in  WIDTH  rt value (multiplier / divisor)
- hi_we  in  1  mthi write enable
- lo_we  in  1  mtlo write enable
- wdata  in  WIDTH  mthi/mtlo data
- busy  out  1  high while an operation is in flight
- done  out  1  one-cycle pulse after HI/LO receive a result
- hi  out  WIDTH  HI register
- lo  out  WIDTH  LO register

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE, counter=0, internal accumulators=0, busy=0, done=0, hi=0, lo=0.
- States:
  - IDLE: start=1 latches |a|, |b| (magnitudes for signed ops), the sign flags and op; goes to CALC at that edge (the "accept edge").
  - CALC: one iteration per edge for WIDTH edges; counter counts 0..WIDTH-1. Moves to FIX after the last iteration.
  - FIX: applies sign correction and writes HI/LO; returns to IDLE on the same edge.
- Timing:
  - busy=1 from the cycle after the accept edge until the FIX edge; busy=0 in IDLE.
  - HI/LO update on the FIX edge, WIDTH+1 edges after the accept edge (33 for WIDTH=32).
  - done=1 for exactly the cycle following the FIX edge.
- Multiply: shift-add on magnitudes into a 2*WIDTH product. Signed product is negated when the operand signs differ. HI=product[2W-1:W], LO=product[W-1:0].
- Divide: restoring radix-2 on magnitudes.
  - Signed: quotient negated when signs differ; remainder takes the sign of the dividend.
  - LO=quotient, HI=remainder.
- Divide by zero (operand_b=0, div or divu): full latency; result LO=all-ones, HI=operand_a (raw, unmodified).
- Signed overflow (div 0x80000000 / 0xFFFFFFFF): LO=0x80000000, HI=0. This falls out of the magnitude algorithm; no special case is needed.
- start while busy: ignored; the in-flight operation is unaffected.
- hi_we/lo_we in IDLE: the register takes wdata on the next edge.
- hi_we/lo_we while busy or in FIX: ignored.
- start together with hi_we/lo_we in IDLE: start wins and the write is discarded.
- Operand inputs are sampled only at the accept edge; later changes have no effect.
- Reset asserted mid-operation: aborts immediately to reset values, with no done pulse.

Optional Feature:
- Macro MULDIV32_DIV0_FAST_EN.
- Defined: a div/divu with operand_b=0 goes directly from IDLE to FIX. HI/LO are written one edge after the accept edge, done pulses in the following cycle, and busy is high for exactly one cycle.
- Undefined: divide-by-zero uses the full WIDTH+1 latency. All other operations are identical in both builds.

Decomposition:
- Package muldiv_pkg holds:
  - op encodings OP_MULT, OP_MULTU, OP_DIV, OP_DIVU
  - state enum IDLE/CALC/FIX
  - DIV0_QUOTIENT constant (all-ones)
- One sub-module, muldiv_div_step: combinational single restoring-division iteration.
  - Inputs: partial remainder, dividend bit, divisor.
  - Outputs: next remainder, quotient bit.
- Multiply iteration and sign fix remain inline in muldiv32.

Test Plan:
- mult: 0xFFFFFFFF x 0x00000002 -> HI=0xFFFFFFFF, LO=0xFFFFFFFE, done exactly 33 edges after the accept edge. Same operands with multu -> HI=0x00000001, LO=0xFFFFFFFE.
- div: 0xFFFFFFF9 / 0x00000002 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF. divu 7 / 2 -> LO=3, HI=1. Overflow case 0x80000000 / 0xFFFFFFFF with div -> LO=0x80000000, HI=0.
- divu 0x12345678 / 0 -> HI=0x12345678, LO=0xFFFFFFFF. done 33 edges after accept; 1 edge when MULTIPLE MULDIV32_DIV0_FAST_EN is defined.
- In IDLE, hi_we with wdata=0xA5A5A5A5 -> hi=0xA5A5A5A5 next cycle. During a busy mult, a second start and lo_we=1 with 0x5A5A5A5A -> both ignored; only the first product appears.
- Assert reset low at cycle 10 of a divu -> busy=0, hi=lo=0 immediately, no done pulse. After release, mult 3 x 5 -> LO=15, HI=0.
